ifetch_queue: RTL

//  Instruction fetch front end: drives the ir/ir_pc stream consumed by pipeline.

---
 rtl/ifetch_queue.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction fetch front end with DEPTH-entry prefetch FIFO
// Keeps one memory request in flight at most and feeds the pipeline a registered ir/ir_pc stream.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic        ir_valid
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic          outstanding;
  logic          stale;
  logic [31:0]   fifo_data [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          accept;
  logic          resp;
  logic          push;
  logic          pop;
  logic          unused_rpc_lsb;

  // A request is only raised when its response is guaranteed a free FIFO slot.
  assign imem_req  = rst_n && !redirect && !outstanding && (count < FULL);
  assign imem_addr = fetch_pc;
  assign accept    = imem_req && imem_gnt;
  assign resp      = imem_rvalid && outstanding;
  assign push      = resp && !stale && !redirect;
  assign pop       = !redirect && !stall && (count != '0);

  assign unused_rpc_lsb = ^redirect_pc[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      req_pc      <= RESET_PC;
      outstanding <= 1'b0;
      stale       <= 1'b0;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      // A response still in flight belongs to the old stream; one returning now is simply dropped.
      stale    <= outstanding && !imem_rvalid;
      if (resp) begin
        outstanding <= 1'b0;
      end
    end else if (accept) begin
      outstanding <= 1'b1;
      req_pc      <= fetch_pc;
      fetch_pc    <= fetch_pc + 32'd4;
    end else if (resp) begin
      outstanding <= 1'b0;
      stale       <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]   <= req_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Output register: redirect beats stall; an empty FIFO injects a NOP bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir       <= 32'h0;
      ir_pc    <= 32'h0;
      ir_valid <= 1'b0;
    end else if (redirect) begin
      ir       <= 32'h0;
      ir_pc    <= 32'h0;
      ir_valid <= 1'b0;
    end else if (!stall) begin
      if (count != '0) begin
        ir       <= fifo_data[rd_ptr];
        ir_pc    <= fifo_pc[rd_ptr];
        ir_valid <= 1'b1;
      end else begin
        ir       <= 32'h0;
        ir_valid <= 1'b0;
      end
    end
  end

endmodule
